// File: rtl/vram_scheduler.sv
// Four-slot video memory scheduler: tile read, glyph read, CPU slot.
// Drives the shared single-port bus and registers RGB888 for the DAC.
module vram_scheduler #(
  parameter logic [15:0] TILE_BASE  = 16'd40000,
  parameter logic [15:0] GLYPH_BASE = 16'd60000,
  parameter int unsigned MAP_WIDTH  = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_start,
  input  logic        bright,
  input  logic [15:0] hCount,
  input  logic [15:0] vCount,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        pixel_valid,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    TILE,
    GLYPH,
    PIX,
    CPUD
  } state_t;

  localparam logic [15:0] MW16 = 16'(MAP_WIDTH);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] h_q;
  logic [15:0] v_q;
  logic        bright_q;
  logic        issue;
  logic        accept;
  logic        fetching;
  logic [15:0] row_off;
  logic [15:0] tile_addr;
  logic [15:0] glyph_addr;

  assign fetching = (state == TILE) || (state == GLYPH) || (state == PIX);
  assign accept   = pix_start && ((state == IDLE) || (state == CPUD));

  assign row_off    = {2'b00, v_q[15:2]} * MW16;
  assign tile_addr  = TILE_BASE + {2'b00, h_q[15:2]} + row_off;
  assign glyph_addr = GLYPH_BASE + {mem_rdata[11:0], 4'b0000}
                    + {12'd0, v_q[1:0], h_q[1:0]};

  assign cpu_ack   = (state == CPUD);
  assign cpu_rdata = cpu_ack ? mem_rdata : 16'd0;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    mem_addr  = 16'd0;
    mem_we    = 1'b0;
    mem_wdata = 16'd0;
    unique case (state)
      IDLE: begin
        if (pix_start) begin
          state_nxt = TILE;
        end else if (cpu_req) begin
          issue     = 1'b1;
          state_nxt = CPUD;
        end
      end
      TILE: begin
        mem_addr  = tile_addr;
        state_nxt = GLYPH;
      end
      GLYPH: begin
        mem_addr  = glyph_addr;
        state_nxt = PIX;
      end
      PIX: begin
        if (cpu_req) begin
          issue     = 1'b1;
          state_nxt = CPUD;
        end else begin
          state_nxt = IDLE;
        end
      end
      CPUD: state_nxt = pix_start ? TILE : IDLE;
      default: state_nxt = IDLE;
    endcase
    // no bus access may leak out while reset holds the FSM in IDLE
    if (issue && !reset) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      h_q      <= 16'd0;
      v_q      <= 16'd0;
      bright_q <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        h_q      <= hCount;
        v_q      <= vCount;
        bright_q <= bright;
      end
      if (pix_start && fetching) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= (state == PIX);
      if (state == PIX) begin
        if (bright_q) begin
          VGA_R <= {mem_rdata[15:11], 3'b000};
          VGA_G <= {mem_rdata[10:5], 2'b00};
          VGA_B <= {mem_rdata[4:0], 3'b000};
        end else begin
          VGA_R <= 8'd0;
          VGA_G <= 8'd0;
          VGA_B <= 8'd0;
        end
      end
    end
  end

endmodule
